// File: rtl/fetch.sv
// Instruction fetch: PC, word-addressed imem and IF/ID register. Optional macro FETCH_MISALIGN_CHK_EN.
// Latency: one cycle from PC to IR_if/NPC_if; a redirect costs one bubble.
// Backpressure: stall holds PC and IF/ID; br_taken overrides stall and HALT.
module fetch #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          br_taken,
  input  logic [31:0]                   br_target,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   NPC_if,
  output logic [31:0]                   IR_if,
  output logic                          valid_if,
  output logic                          halted,
  output logic                          misalign_err,
  output logic [31:0]                   fetch_cnt
);

  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic [31:0]   imem [IMEM_DEPTH];
  logic [AW-1:0] fetch_idx;
  logic [31:0]   fetch_word;
  logic          br_misaligned;
  logic [31:0]   br_pc;

  // Upper PC bits are ignored, so fetches wrap modulo the memory size.
  assign fetch_idx  = pc[AW+1:2];
  assign fetch_word = imem[fetch_idx];
  assign pc_plus4   = pc + 32'd4;

`ifdef FETCH_MISALIGN_CHK_EN
  // A misaligned redirect is refused and parks the block in FAULT.
  assign br_misaligned = (br_target[1:0] != 2'b00);
  assign br_pc         = br_target;
`else
  // Without checking, the low address bits are simply dropped.
  assign br_misaligned = 1'b0;
  assign br_pc         = br_target & 32'hFFFF_FFFC;
`endif

  // Write port; the fetch read in the same edge still sees the old word.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  // Fetch FSM: reset > fault hold > redirect > halt bubble > stall > fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RUN;
      pc           <= RESET_PC;
      IR_if        <= NOP_WORD;
      NPC_if       <= 32'd0;
      valid_if     <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      fetch_cnt    <= 32'd0;
    end else if (state == S_FAULT) begin
      state <= S_FAULT;
    end else if (br_taken) begin
      IR_if    <= NOP_WORD;
      valid_if <= 1'b0;
      halted   <= 1'b0;
      if (br_misaligned) begin
        state        <= S_FAULT;
        misalign_err <= 1'b1;
      end else begin
        state <= S_RUN;
        pc    <= br_pc;
      end
    end else if (state == S_HALT) begin
      IR_if    <= NOP_WORD;
      valid_if <= 1'b0;
    end else if (!stall) begin
      IR_if     <= fetch_word;
      NPC_if    <= pc_plus4;
      valid_if  <= 1'b1;
      pc        <= pc_plus4;
      fetch_cnt <= fetch_cnt + 32'd1;
      // The halt word itself is delivered; the PC parks just past it.
      if (fetch_word[31:26] == 6'h3F) begin
        state  <= S_HALT;
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios plus a random run against a reference model.
module tb_fetch;

  localparam int          DEPTH    = 256;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, imem_we;
  logic [31:0] br_target, imem_wdata;
  logic [7:0]  imem_waddr;
  logic [31:0] NPC_if, IR_if, fetch_cnt;
  logic        valid_if, halted, misalign_err;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc, m_ir, m_npc, m_cnt;
  logic        m_vld, m_halt, m_fault;

  fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .NPC_if(NPC_if), .IR_if(IR_if), .valid_if(valid_if), .halted(halted),
    .misalign_err(misalign_err), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Behavioural model: one call per clock edge, applying the priority rules directly.
  task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] t,
                            input logic we, input logic [7:0] wa, input logic [31:0] wd);
    logic [31:0] word;
    word = m_mem[(m_pc / 4) % DEPTH];
    if (r) begin
      m_pc = RESET_PC; m_ir = NOP; m_npc = 0; m_vld = 0; m_halt = 0; m_fault = 0; m_cnt = 0;
    end else if (m_fault) begin
      m_fault = 1;
    end else if (b) begin
      m_ir = NOP; m_vld = 0; m_halt = 0;
      if (CHK && (t % 4 != 0)) m_fault = 1;
      else m_pc = t - (t % 4);
    end else if (m_halt) begin
      m_ir = NOP; m_vld = 0;
    end else if (!s) begin
      m_ir = word; m_npc = m_pc + 4; m_vld = 1; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
      if ((word >> 26) == 32'd63) m_halt = 1;
    end
    if (we) m_mem[wa] = wd;
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t,
                      input logic we, input logic [7:0] wa, input logic [31:0] wd);
    rst = r; stall = s; br_taken = b; br_target = t;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    model_step(r, s, b, t, we, wa, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      if (w[31:26] == 6'h3F) w[31] = 1'b0;
      if (i == 0) w = 32'h11;
      if (i == 1) w = 32'h22;
      if (i == 2) w = 32'h33;
      if (i == 3) w = 32'hFC00_0000;
      step(1, 0, 0, 0, 1, i[7:0], w);
    end
    step(1, 0, 0, 0, 0, 0, 0);
    checks++; if (IR_if !== NOP) begin fails++; $display("FAIL reset_ir: got %h want %h", IR_if, NOP); end
    checks++; if (NPC_if !== 32'h0) begin fails++; $display("FAIL reset_npc: got %h want 0", NPC_if); end
    checks++; if (valid_if !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid_if); end
    checks++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (misalign_err !== 1'b0) begin fails++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
    checks++; if (fetch_cnt !== 32'h0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", fetch_cnt); end
  endtask

  task automatic test_fetch();
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (IR_if !== 32'h11 || NPC_if !== 32'h4 || valid_if !== 1'b1)
      begin fails++; $display("FAIL fetch0: got ir=%h npc=%h v=%b want 11/4/1", IR_if, NPC_if, valid_if); end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (IR_if !== 32'h22 || NPC_if !== 32'h8 || fetch_cnt !== 32'd2)
      begin fails++; $display("FAIL fetch1: got ir=%h npc=%h cnt=%0d want 22/8/2", IR_if, NPC_if, fetch_cnt); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      checks++; if (IR_if !== 32'h22 || NPC_if !== 32'h8 || valid_if !== 1'b1 || fetch_cnt !== 32'd2)
        begin fails++; $display("FAIL stall_hold%0d: got ir=%h npc=%h v=%b cnt=%0d want 22/8/1/2", i, IR_if, NPC_if, valid_if, fetch_cnt); end
    end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (IR_if !== 32'h33 || NPC_if !== 32'hC || fetch_cnt !== 32'd3)
      begin fails++; $display("FAIL stall_resume: got ir=%h npc=%h cnt=%0d want 33/c/3", IR_if, NPC_if, fetch_cnt); end
  endtask

  task automatic test_halt();
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (IR_if !== 32'hFC00_0000 || valid_if !== 1'b1 || halted !== 1'b1 || fetch_cnt !== 32'd4 || NPC_if !== 32'h10)
      begin fails++; $display("FAIL halt_enter: got ir=%h v=%b h=%b cnt=%0d npc=%h", IR_if, valid_if, halted, fetch_cnt, NPC_if); end
    for (int i = 0; i < 5; i++) begin
      step(0, i[0], 0, 0, 0, 0, 0);
      checks++; if (valid_if !== 1'b0 || IR_if !== NOP || halted !== 1'b1 || fetch_cnt !== 32'd4)
        begin fails++; $display("FAIL halt_hold%0d: got v=%b ir=%h h=%b cnt=%0d want 0/0/1/4", i, valid_if, IR_if, halted, fetch_cnt); end
    end
    step(0, 0, 1, 32'h0, 0, 0, 0);
    checks++; if (valid_if !== 1'b0 || halted !== 1'b0 || IR_if !== NOP)
      begin fails++; $display("FAIL halt_exit_bubble: got v=%b h=%b ir=%h want 0/0/0", valid_if, halted, IR_if); end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (IR_if !== 32'h11 || NPC_if !== 32'h4 || valid_if !== 1'b1 || fetch_cnt !== 32'd5)
      begin fails++; $display("FAIL halt_resume: got ir=%h npc=%h v=%b cnt=%0d want 11/4/1/5", IR_if, NPC_if, valid_if, fetch_cnt); end
  endtask

  task automatic test_branch_stall();
    step(0, 1, 1, 32'h40, 0, 0, 0);
    checks++; if (valid_if !== 1'b0 || IR_if !== NOP)
      begin fails++; $display("FAIL br_bubble: got v=%b ir=%h want 0/0", valid_if, IR_if); end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (IR_if !== m_mem[16] || NPC_if !== 32'h44 || valid_if !== 1'b1 || fetch_cnt !== 32'd6)
      begin fails++; $display("FAIL br_target: got ir=%h npc=%h v=%b cnt=%0d want %h/44/1/6", IR_if, NPC_if, valid_if, fetch_cnt, m_mem[16]); end
  endtask

  task automatic test_wrap();
    logic [31:0] last;
    last = m_mem[255];
    step(0, 0, 1, 32'h3FC, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (IR_if !== last || NPC_if !== 32'h400)
      begin fails++; $display("FAIL wrap_last: got ir=%h npc=%h want %h/400", IR_if, NPC_if, last); end
    step(0, 0, 0, 0, 1, 8'd0, 32'hABCD_0123);
    checks++; if (IR_if !== 32'h11 || NPC_if !== 32'h404 || fetch_cnt !== 32'd8)
      begin fails++; $display("FAIL wrap_rd_old: got ir=%h npc=%h cnt=%0d want 11/404/8", IR_if, NPC_if, fetch_cnt); end
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (IR_if !== last || NPC_if !== 32'h0)
      begin fails++; $display("FAIL pc_wrap32: got ir=%h npc=%h want %h/0", IR_if, NPC_if, last); end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (IR_if !== 32'hABCD_0123 || NPC_if !== 32'h4 || fetch_cnt !== 32'd10)
      begin fails++; $display("FAIL wrap_new_word: got ir=%h npc=%h cnt=%0d want abcd0123/4/10", IR_if, NPC_if, fetch_cnt); end
  endtask

  task automatic test_misalign();
    step(0, 0, 1, 32'h42, 0, 0, 0);
    if (CHK) begin
      checks++; if (misalign_err !== 1'b1 || valid_if !== 1'b0 || IR_if !== NOP)
        begin fails++; $display("FAIL misalign_enter: got err=%b v=%b ir=%h want 1/0/0", misalign_err, valid_if, IR_if); end
      for (int i = 0; i < 3; i++) begin
        step(0, 0, i[0], 32'h0, 0, 0, 0);
        checks++; if (misalign_err !== 1'b1 || valid_if !== 1'b0 || fetch_cnt !== 32'd10 || IR_if !== NOP)
          begin fails++; $display("FAIL misalign_hold%0d: got err=%b v=%b cnt=%0d ir=%h", i, misalign_err, valid_if, fetch_cnt, IR_if); end
      end
      step(1, 0, 0, 0, 0, 0, 0);
      checks++; if (misalign_err !== 1'b0 || fetch_cnt !== 32'd0)
        begin fails++; $display("FAIL misalign_clear: got err=%b cnt=%0d want 0/0", misalign_err, fetch_cnt); end
    end else begin
      checks++; if (misalign_err !== 1'b0 || valid_if !== 1'b0)
        begin fails++; $display("FAIL misalign_bubble: got err=%b v=%b want 0/0", misalign_err, valid_if); end
      step(0, 0, 0, 0, 0, 0, 0);
      checks++; if (IR_if !== m_mem[16] || NPC_if !== 32'h44 || misalign_err !== 1'b0)
        begin fails++; $display("FAIL misalign_force: got ir=%h npc=%h err=%b want %h/44/0", IR_if, NPC_if, misalign_err, m_mem[16]); end
    end
  endtask

  task automatic test_random();
    logic        r, s, b, we;
    logic [31:0] t, wd;
    logic [7:0]  wa;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(63) == 0);
      s  = ($urandom_range(3) == 0);
      b  = ($urandom_range(7) == 0);
      t  = $urandom;
      if ($urandom_range(15) != 0) t[1:0] = 2'b00;
      if ($urandom_range(1) == 0) t = t & 32'h0000_07FF;
      we = ($urandom_range(3) == 0);
      wa = 8'($urandom_range(255));
      wd = $urandom;
      if ($urandom_range(15) == 0) wd[31:26] = 6'h3F;
      step(r, s, b, t, we, wa, wd);
      checks++; if (IR_if !== m_ir) begin fails++; $display("FAIL rnd_ir cyc %0d: got %h want %h", n, IR_if, m_ir); end
      checks++; if (NPC_if !== m_npc) begin fails++; $display("FAIL rnd_npc cyc %0d: got %h want %h", n, NPC_if, m_npc); end
      checks++; if (valid_if !== m_vld) begin fails++; $display("FAIL rnd_valid cyc %0d: got %b want %b", n, valid_if, m_vld); end
      checks++; if (halted !== m_halt) begin fails++; $display("FAIL rnd_halted cyc %0d: got %b want %b", n, halted, m_halt); end
      checks++; if (misalign_err !== m_fault) begin fails++; $display("FAIL rnd_misalign cyc %0d: got %b want %b", n, misalign_err, m_fault); end
      checks++; if (fetch_cnt !== m_cnt) begin fails++; $display("FAIL rnd_cnt cyc %0d: got %0d want %0d", n, fetch_cnt, m_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    imem_we = 1'b0; imem_waddr = 8'h0; imem_wdata = 32'h0;
    m_pc = RESET_PC; m_ir = NOP; m_npc = 0; m_cnt = 0; m_vld = 0; m_halt = 0; m_fault = 0;
    test_reset();
    test_fetch();
    test_stall();
    test_halt();
    test_branch_stall();
    test_wrap();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
